// File: rtl/fb_pkg.sv
// Shared dimensions and FSM state encoding for the 64x64 single-bit framebuffer.
package fb_pkg;
  localparam int FB_DIM = 64;
  localparam int FB_AW  = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SCAN  = 2'd2
  } fb_state_t;
endpackage

// File: rtl/fb_row_cnt.sv
// Row counter shared by the clear sweep and the scanout; flags the last row.
module fb_row_cnt
  import fb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_zero,
  input  logic             advance,
  output logic [FB_AW-1:0] cnt,
  output logic             last
);
  always_ff @(posedge clk) begin
    if (rst || load_zero) begin
      cnt <= '0;
    end else if (advance) begin
      cnt <= cnt + FB_AW'(1);
    end
  end

  assign last = (cnt == FB_AW'(FB_DIM - 1));
endmodule

// File: rtl/pixel_framebuffer.sv
// 64x64 bit framebuffer: pixel plot, one-row-per-cycle clear, row-by-row scanout.
// Optional FB_PIXEL_COUNT_EN adds pix_count, the number of set pixels.
module pixel_framebuffer
  import fb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              plot_valid,
  input  logic [FB_AW-1:0]  plot_x,
  input  logic [FB_AW-1:0]  plot_y,
  output logic              plot_ready,
  input  logic              clear_req,
  input  logic              scan_start,
  output logic              busy,
  output logic              row_valid,
  input  logic              row_ready,
  output logic [FB_AW-1:0]  row_idx,
  output logic [FB_DIM-1:0] row_data,
  output logic              scan_done
`ifdef FB_PIXEL_COUNT_EN
  ,
  output logic [12:0]       pix_count
`endif
);
  fb_state_t state, next_state;

  logic [FB_DIM-1:0][FB_DIM-1:0] mem;

  logic [FB_AW-1:0] cnt;
  logic [FB_AW-1:0] cnt_inc;
  logic             cnt_last;
  logic             cnt_load;
  logic             cnt_adv;

  logic do_plot;
  logic clear_row;
  logic scan_load;
  logic scan_adv;
  logic scan_end;

  fb_row_cnt u_row_cnt (
    .clk       (clk),
    .rst       (rst),
    .load_zero (cnt_load),
    .advance   (cnt_adv),
    .cnt       (cnt),
    .last      (cnt_last)
  );

  assign cnt_inc = cnt + FB_AW'(1);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    plot_ready = 1'b0;
    cnt_load   = 1'b0;
    cnt_adv    = 1'b0;
    do_plot    = 1'b0;
    clear_row  = 1'b0;
    scan_load  = 1'b0;
    scan_adv   = 1'b0;
    scan_end   = 1'b0;
    case (state)
      IDLE: begin
        // Clear beats scan beats plot; plot_ready is combinational on the requests.
        plot_ready = !clear_req && !scan_start;
        if (clear_req) begin
          next_state = CLEAR;
          cnt_load   = 1'b1;
        end else if (scan_start) begin
          next_state = SCAN;
          cnt_load   = 1'b1;
          scan_load  = 1'b1;
        end else begin
          do_plot = plot_valid;
        end
      end
      CLEAR: begin
        clear_row = 1'b1;
        cnt_adv   = 1'b1;
        if (cnt_last) begin
          next_state = IDLE;
        end
      end
      SCAN: begin
        if (row_valid && row_ready) begin
          if (cnt_last) begin
            next_state = IDLE;
            scan_end   = 1'b1;
          end else begin
            cnt_adv  = 1'b1;
            scan_adv = 1'b1;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem <= '0;
    end else if (do_plot) begin
      mem[plot_y][plot_x] <= 1'b1;
    end else if (clear_row) begin
      mem[cnt] <= '0;
    end
  end

  // Row registers are reloaded from the array only on entry or handshake, so they hold under stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_valid <= 1'b0;
      row_idx   <= '0;
      row_data  <= '0;
      scan_done <= 1'b0;
    end else begin
      scan_done <= scan_end;
      if (scan_load) begin
        row_valid <= 1'b1;
        row_idx   <= '0;
        row_data  <= mem[0];
      end else if (scan_adv) begin
        row_idx  <= cnt_inc;
        row_data <= mem[cnt_inc];
      end else if (scan_end) begin
        row_valid <= 1'b0;
      end
    end
  end

`ifdef FB_PIXEL_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst || (state == IDLE && clear_req)) begin
      pix_count <= '0;
    end else if (do_plot && !mem[plot_y][plot_x]) begin
      pix_count <= pix_count + 13'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pixel_framebuffer.sv
// Directed self-checking bench for pixel_framebuffer.
module tb_pixel_framebuffer;
  import fb_pkg::*;

  logic              clk;
  logic              rst;
  logic              plot_valid;
  logic [FB_AW-1:0]  plot_x;
  logic [FB_AW-1:0]  plot_y;
  logic              plot_ready;
  logic              clear_req;
  logic              scan_start;
  logic              busy;
  logic              row_valid;
  logic              row_ready;
  logic [FB_AW-1:0]  row_idx;
  logic [FB_DIM-1:0] row_data;
  logic              scan_done;
`ifdef FB_PIXEL_COUNT_EN
  logic [12:0]       pix_count;
`endif

  int nchecks = 0;
  int nfail   = 0;
  logic [FB_DIM-1:0] exp_mem [FB_DIM];

  pixel_framebuffer dut (
    .clk        (clk),
    .rst        (rst),
    .plot_valid (plot_valid),
    .plot_x     (plot_x),
    .plot_y     (plot_y),
    .plot_ready (plot_ready),
    .clear_req  (clear_req),
    .scan_start (scan_start),
    .busy       (busy),
    .row_valid  (row_valid),
    .row_ready  (row_ready),
    .row_idx    (row_idx),
    .row_data   (row_data),
    .scan_done  (scan_done)
`ifdef FB_PIXEL_COUNT_EN
    ,
    .pix_count  (pix_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_exp();
    for (int i = 0; i < FB_DIM; i++) exp_mem[i] = '0;
  endtask

  task automatic plot(input int x, input int y);
    plot_valid = 1'b1;
    plot_x     = FB_AW'(x);
    plot_y     = FB_AW'(y);
    #1;
    nchecks++;
    if (plot_ready !== 1'b1) begin
      nfail++;
      $display("FAIL plot_ready_idle (%0d,%0d): got %b want 1", x, y, plot_ready);
    end
    step();
    plot_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    repeat (FB_DIM) step();
  endtask

  task automatic scan_check(input string name, input int stall_row, input int stall_len);
    row_ready  = 1'b1;
    scan_start = 1'b1;
    step();
    scan_start = 1'b0;
    for (int r = 0; r < FB_DIM; r++) begin
      if (r == stall_row) begin
        row_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          step();
          nchecks++;
          if (row_valid !== 1'b1 || row_idx !== FB_AW'(r) || row_data !== exp_mem[r]) begin
            nfail++;
            $display("FAIL %s_stall row %0d cyc %0d: valid=%b idx=%0d data=%h want idx=%0d data=%h",
                     name, r, s, row_valid, row_idx, row_data, r, exp_mem[r]);
          end
        end
        row_ready = 1'b1;
      end
      nchecks++;
      if (row_valid !== 1'b1 || row_idx !== FB_AW'(r) || row_data !== exp_mem[r]) begin
        nfail++;
        $display("FAIL %s_row %0d: valid=%b idx=%0d data=%h want idx=%0d data=%h",
                 name, r, row_valid, row_idx, row_data, r, exp_mem[r]);
      end
      step();
    end
    nchecks++;
    if (scan_done !== 1'b1 || busy !== 1'b0 || row_valid !== 1'b0) begin
      nfail++;
      $display("FAIL %s_done: scan_done=%b busy=%b row_valid=%b want 1 0 0",
               name, scan_done, busy, row_valid);
    end
    step();
    nchecks++;
    if (scan_done !== 1'b0) begin
      nfail++;
      $display("FAIL %s_done_pulse: scan_done=%b want 0", name, scan_done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    plot_valid = 1'b0; plot_x = '0; plot_y = '0;
    clear_req = 1'b0; scan_start = 1'b0; row_ready = 1'b0;
    repeat (3) step();
    nchecks++;
    if (row_valid !== 1'b0 || row_idx !== '0 || row_data !== '0 || scan_done !== 1'b0 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL reset_outputs: valid=%b idx=%0d data=%h done=%b busy=%b want all 0",
               row_valid, row_idx, row_data, scan_done, busy);
    end
    rst = 1'b0;
    #1;
    nchecks++;
    if (plot_ready !== 1'b1) begin
      nfail++;
      $display("FAIL reset_plot_ready: got %b want 1", plot_ready);
    end
    step();
  endtask

  task automatic test_plot_scan();
    plot(3, 5);
    plot(63, 63);
    plot(0, 0);
    clear_exp();
    exp_mem[0]  = 64'h0000_0000_0000_0001;
    exp_mem[5]  = 64'h0000_0000_0000_0008;
    exp_mem[63] = 64'h8000_0000_0000_0000;
    scan_check("plot_scan", -1, 0);
  endtask

  task automatic test_backpressure();
    scan_check("backpressure", 7, 10);
  endtask

  task automatic test_clear_collision();
    clear_req  = 1'b1;
    plot_valid = 1'b1;
    plot_x     = 6'd10;
    plot_y     = 6'd10;
    #1;
    nchecks++;
    if (plot_ready !== 1'b0) begin
      nfail++;
      $display("FAIL clear_plot_ready: got %b want 0", plot_ready);
    end
    step();
    clear_req  = 1'b0;
    plot_valid = 1'b0;
    for (int i = 0; i < FB_DIM; i++) begin
      nchecks++;
      if (busy !== 1'b1) begin
        nfail++;
        $display("FAIL clear_busy cyc %0d: got %b want 1", i, busy);
      end
      step();
    end
    nchecks++;
    if (busy !== 1'b0) begin
      nfail++;
      $display("FAIL clear_busy_end: got %b want 0", busy);
    end
    clear_exp();
    scan_check("after_clear", -1, 0);
  endtask

  task automatic test_plot_busy();
    int bad_rdy;
    bad_rdy    = 0;
    row_ready  = 1'b1;
    scan_start = 1'b1;
    plot_valid = 1'b1;
    plot_x     = 6'd5;
    plot_y     = 6'd9;
    step();
    scan_start = 1'b0;
    for (int r = 0; r < FB_DIM; r++) begin
      if (plot_ready !== 1'b0) bad_rdy++;
      step();
    end
    nchecks++;
    if (bad_rdy != 0) begin
      nfail++;
      $display("FAIL plot_busy_ready: plot_ready high in %0d scan cycles, want 0", bad_rdy);
    end
    nchecks++;
    if (plot_ready !== 1'b1 || scan_done !== 1'b1) begin
      nfail++;
      $display("FAIL plot_busy_first_idle: plot_ready=%b scan_done=%b want 1 1", plot_ready, scan_done);
    end
    step();
    plot_valid = 1'b0;
    clear_exp();
    exp_mem[9] = 64'h0000_0000_0000_0020;
    scan_check("plot_busy", -1, 0);
  endtask

  task automatic test_reset_mid_scan();
    row_ready  = 1'b1;
    scan_start = 1'b1;
    step();
    scan_start = 1'b0;
    repeat (30) step();
    nchecks++;
    if (row_idx !== 6'd30 || row_valid !== 1'b1) begin
      nfail++;
      $display("FAIL midscan_pos: idx=%0d valid=%b want 30 1", row_idx, row_valid);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    nchecks++;
    if (row_valid !== 1'b0 || busy !== 1'b0 || row_idx !== '0 || scan_done !== 1'b0) begin
      nfail++;
      $display("FAIL midscan_reset: valid=%b busy=%b idx=%0d done=%b want 0 0 0 0",
               row_valid, busy, row_idx, scan_done);
    end
    clear_exp();
    scan_check("after_reset", -1, 0);
  endtask

`ifdef FB_PIXEL_COUNT_EN
  task automatic test_pix_count();
    plot(1, 1);
    plot(1, 1);
    plot(2, 2);
    nchecks++;
    if (pix_count !== 13'd2) begin
      nfail++;
      $display("FAIL pix_count_plots: got %0d want 2", pix_count);
    end
    do_clear();
    nchecks++;
    if (pix_count !== 13'd0) begin
      nfail++;
      $display("FAIL pix_count_clear: got %0d want 0", pix_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_plot_scan();
    test_backpressure();
    test_clear_collision();
    test_plot_busy();
    test_reset_mid_scan();
`ifdef FB_PIXEL_COUNT_EN
    test_pix_count();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
    $finish;
  end
endmodule

// File: doc/pixel_framebuffer.md
# pixel_framebuffer

Single-bit 64x64 framebuffer that sits downstream of the line rasterizer. It accepts pixel plot requests (x,y) over a valid/ready handshake and sets the addressed bit. It clears the whole frame in one row per cycle. It scans the frame out row by row over a second valid/ready handshake for display or readback.

## Interface
- FB_DIM, 64: frame width and height; fixed, power of two.
- FB_AW, 6: coordinate width, log2(FB_DIM).
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- plot_valid  in  1  pixel write request.
- plot_x  in  FB_AW  pixel column.
- plot_y  in  FB_AW  pixel row.
- plot_ready  out  1  write accepted when plot_valid && plot_ready.
- clear_req  in  1  request full-frame clear; sampled in IDLE only.
- scan_start  in  1  request full-frame scanout; sampled in IDLE only.
- busy  out  1  high in CLEAR and SCAN.
- row_valid  out  1  row_data/row_idx valid.
- row_ready  in  1  consumer accepts the row.
- row_idx  out  FB_AW  index of the presented row.
- row_data  out  FB_DIM  row contents; bit x = pixel (x, row_idx).
- scan_done  out  1  one-cycle pulse after the last row is accepted.

## Operation
- Storage: 64x64 flop array, mem[y][x].
- States: IDLE, CLEAR, SCAN.
- IDLE priority order: clear_req, then scan_start, then plot.
  - plot_ready = (state==IDLE) && !clear_req && !scan_start. This is a combinational dependency on the request inputs.
  - On a plot handshake, mem[plot_y][plot_x] <= 1. Other bits are unchanged.
  - Re-plotting a set pixel is legal and has no effect.
- CLEAR:
  - Entered from IDLE when clear_req is high. Row counter starts at 0.
  - Each cycle zeroes mem[cnt] and increments cnt.
  - After cnt==63, go to IDLE.
  - clear_req and scan_start are ignored while busy.
- SCAN:
  - Entered from IDLE when scan_start is high. Row counter starts at 0.
  - row_valid is high throughout SCAN. row_data = mem[cnt] and row_idx = cnt, both registered.
  - Data and index hold stable until a handshake (row_valid && row_ready).
  - On handshake, cnt increments and the next row is presented on the following cycle.
  - A handshake on row 63 moves to IDLE, drops row_valid, and pulses scan_done for one cycle.
- plot_ready is 0 in CLEAR and SCAN, so the frame cannot change mid-scan or mid-clear.
- Coordinates are FB_AW bits, so every coordinate is in range and there is no wrap handling.
- Reset: from any state, including mid-CLEAR or mid-SCAN.
  - state goes to IDLE and the whole array is zeroed in the reset cycle.
  - row_valid=0, row_idx=0, row_data=0, scan_done=0, busy=0.
  - plot_ready follows its IDLE equation after rst is released.

## Timing
- Plot: a handshake at cycle N makes the bit visible in mem at N+1. A scan_start at N+1 outputs that bit.
- Clear: accepted at N; rows 0..63 are zeroed on edges N+1..N+64; busy is high N+1..N+64; IDLE from N+65.
- Scan: accepted at N; row 0 is valid at N+1.
  - With row_ready held high, one row is transferred per cycle: rows 0..63 at N+1..N+64.
  - scan_done is high at N+65 with busy low.
- Back-pressure: row_ready low holds the current row indefinitely. No row is skipped or duplicated.

## Configuration
- FB_PIXEL_COUNT_EN defined:
  - Adds an output port pix_count [12:0], holding the number of set pixels.
  - pix_count increments only on a plot handshake that flips a 0 bit to 1.
  - It is zeroed by reset and when CLEAR is entered. Range is 0..4096.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Package fb_pkg: FB_DIM, FB_AW, and the state enum fb_state_t {IDLE, CLEAR, SCAN}.
- Sub-module fb_row_cnt: FB_AW-bit row counter with load-zero, advance, and a terminal flag (cnt==FB_DIM-1). It is shared by CLEAR and SCAN.
- Top level: FSM, flop array, plot write decode, scan output registers.

## Test plan
- Reset, then plot (3,5), (63,63), (0,0), then scan with row_ready=1. Expect:
  - row 0 = bit 0 set; row 5 = bit 3 set; row 63 = bit 63 set; all other rows zero.
  - scan_done at cycle N+65.
- Mid-scan back-pressure: drop row_ready for 10 cycles at row 7. Expect row_idx=7 and row_data to hold stable, then rows 8..63 in order with no skips.
- Same-cycle clear_req and plot_valid in IDLE. Expect:
  - plot_ready=0 and CLEAR taken, busy high for 64 cycles.
  - A subsequent scan returns all-zero rows.
- Plot while busy: plot_valid held during SCAN. Expect plot_ready=0 until IDLE, and the write is accepted in the first IDLE cycle.
- Assert rst at row 30 of a scan. Expect:
  - row_valid=0 and IDLE on the next cycle.
  - The next scan returns all-zero rows.
- With FB_PIXEL_COUNT_EN: plot (1,1) twice, then (2,2). Expect pix_count=2; after a clear, pix_count=0.
